tracer_trace_collector: RTL and testbench
=========================================

Name: tracer_trace_collector

Overview:
- Downstream stage of the tracer element chain: after each frame it drives store_trace, shifts every element's 16-bit accumulated trace out of the chain tail and buffers the words in an internal FIFO.
- Presents the frame as a valid/ready stream with tlast, for the PS/DMA side.
- Admits a frame only if the FIFO can hold all of it; otherwise the frame is dropped and counted.

Parameters:
- NUM_ELEM, 64, tracer elements in the chain (words per frame); >=2.
- TRACE_W, 16, trace word width; must match the element acc_trace width.
- FIFO_DEPTH, 128, buffer entries; power of two, >= NUM_ELEM.

Ports:
- s_axi_aclk  in  1  sole clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- frame_done  in  1  1-cycle pulse from frame controller: traces final, start readout
- clear_stats  in  1  1-cycle pulse: zero drop_cnt and overflow
- store_trace  out  1  to chain head; each high cycle shifts the chain by one element
- chain_trace  in  TRACE_W  acc_trace of the last chain element
- m_tvalid  out  1  stream word valid
- m_tready  in  1  consumer ready
- m_tdata  out  TRACE_W  trace word
- m_tlast  out  1  high on the last word of a frame
- busy  out  1  high while in SHIFT
- frame_cnt  out  16  frames fully captured, wraps 0xFFFF->0
- drop_cnt  out  16  frames dropped, saturates at 0xFFFF
- overflow  out  1  sticky; set on any drop

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. Async assertion forces store_trace low immediately. The chain may be left part-shifted; recovery belongs to the frame controller.
- FSM IDLE: on frame_done, if (FIFO_DEPTH - fifo_count) >= NUM_ELEM, go to SHIFT with idx=0. Otherwise stay IDLE, set overflow, drop_cnt++ (saturating).
- Free space is taken from fifo_count in the frame_done cycle. A pop in that same cycle is not credited.
- FSM SHIFT: store_trace=1 (registered; first high the cycle after frame_done), busy=1.
  - Each SHIFT cycle, on the closing edge: push {tlast=(idx==NUM_ELEM-1), chain_trace} and idx++.
  - Word order is element NUM_ELEM-1 first, element 0 last.
  - At idx==NUM_ELEM-1: return to IDLE and frame_cnt++.
  - store_trace stays high for exactly NUM_ELEM consecutive cycles.
- frame_done while in SHIFT: treated as a drop (overflow set, drop_cnt++); the current frame is unaffected.
- The admission check guarantees a push never meets a full FIFO. Bench asserts no push with fifo_count==FIFO_DEPTH.
- FIFO: synchronous, show-ahead.
  - m_tvalid = (count != 0); m_tdata/m_tlast come from the head entry.
  - Pop occurs when m_tvalid && m_tready.
  - Push and pop in the same cycle leave count unchanged.
  - First word is visible (m_tvalid=1) the cycle after its push edge.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- Stream rule: while m_tvalid && !m_tready, m_tdata/m_tlast hold stable.
- clear_stats: zeroes drop_cnt and overflow next edge. If coincident with a drop, the drop wins: drop_cnt=1, overflow=1.

Decomposition:
- tracer_pkg holds:
  - TRACE_W default
  - FSM state encoding (IDLE=1'b0, SHIFT=1'b1)
  - clog2 helper
- Sub-module tracer_trace_fifo: width TRACE_W+1, depth FIFO_DEPTH, with push/pop/count/head outputs. Inferred distributed or block RAM with a show-ahead output register.
- Collector FSM, idx counter and stats stay in the top module.

Test Plan (NUM_ELEM=4, FIFO_DEPTH=8, m_tready=1 unless stated):
- Chain model preloaded 0x0011,0x0022,0x0033,0x0044 (elements 0..3); frame_done pulse -> store_trace high exactly 4 cycles starting next cycle; stream emits 0x0044,0x0033,0x0022,0x0011; tlast only on 0x0011; frame_cnt=1.
- m_tready=0, two frames -> count=8, no drop. Third frame_done -> drop_cnt=1, overflow=1, store_trace stays 0. Release ready -> 8 words out, tlast on the 4th and 8th.
- frame_done at shift cycle 2 -> current frame completes intact, drop_cnt=1.
- FIFO at count=5 while popping every cycle, frame_done -> dropped, because free space 3 < 4.
- Random m_tready toggling over 20 frames -> output order and values match the model, data stable while stalled, pointer wrap exercised, frame_cnt=20.
- s_axi_aresetn low during shift cycle 1 -> store_trace, m_tvalid and busy go 0 without a clock edge. After release, a frame_done captures a full frame normally; clear_stats zeroes drop_cnt.

Source files
------------

// File: rtl/tracer_pkg.sv
// Shared types and helpers for the tracer trace collector slice.
package tracer_pkg;

    parameter int unsigned TRACE_W_DEF = 16;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Constant-time ceil(log2(v)); v <= 1 yields 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tracer_trace_collector_if.sv
// Trace word stream towards the PS/DMA side (valid/ready with tlast).
interface tracer_trace_collector_if #(
    parameter int unsigned TRACE_W = 16
) ();

    logic               m_tvalid;
    logic               m_tready;
    logic [TRACE_W-1:0] m_tdata;
    logic               m_tlast;

    modport master (
        output m_tvalid,
        output m_tdata,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast,
        output m_tready
    );

endinterface

// File: rtl/tracer_trace_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible whenever the FIFO is non-empty.
module tracer_trace_fifo
    import tracer_pkg::*;
#(
    parameter int unsigned Width = 17,
    parameter int unsigned Depth = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [Width-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [Width-1:0]      head_o,
    output logic [clog2(Depth):0] count_o
);

    localparam int unsigned AddrW = clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             not_empty, full, push_en, pop_en;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CntW'(Depth));
    assign pop_en    = pop_i && not_empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign push_en   = push_i && (!full || pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = not_empty;
    // Masked so the stream outputs read zero while empty, including straight out of reset.
    assign head_o  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/tracer_trace_collector.sv
// Reads the element chain out after each frame, buffers it and streams it with tlast.
module tracer_trace_collector
    import tracer_pkg::*;
#(
    parameter int unsigned NUM_ELEM   = 64,
    parameter int unsigned TRACE_W    = TRACE_W_DEF,
    parameter int unsigned FIFO_DEPTH = 128
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic                      frame_done,
    input  logic                      clear_stats,
    output logic                      store_trace,
    input  logic [TRACE_W-1:0]        chain_trace,
    tracer_trace_collector_if.master  m_axis,
    output logic                      busy,
    output logic [15:0]               frame_cnt,
    output logic [15:0]               drop_cnt,
    output logic                      overflow
);

    localparam int unsigned IdxW = clog2(NUM_ELEM);
    localparam int unsigned CntW = clog2(FIFO_DEPTH) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ELEM - 1);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;

    logic [CntW-1:0]     fifo_count;
    logic [CntW-1:0]     free_space;
    logic                admit, drop, last_push;
    logic                push;
    logic [TRACE_W:0]    push_data;
    logic                fifo_valid;
    logic [TRACE_W:0]    fifo_head;

    // Space is judged on the count seen in the frame_done cycle; a same-cycle pop is ignored.
    assign free_space = CntW'(FIFO_DEPTH) - fifo_count;
    assign admit      = (free_space >= CntW'(NUM_ELEM));

    // FSM state register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (frame_done && admit) begin
                    state_d = StShift;
                    idx_d   = '0;
                end
            end
            StShift: begin
                idx_d = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        store_trace = 1'b0;
        busy        = 1'b0;
        push        = 1'b0;
        last_push   = 1'b0;
        drop        = 1'b0;
        push_data   = {(idx_q == LastIdx), chain_trace};
        unique case (state_q)
            StIdle: begin
                drop = frame_done && !admit;
            end
            StShift: begin
                store_trace = 1'b1;
                busy        = 1'b1;
                push        = 1'b1;
                last_push   = (idx_q == LastIdx);
                drop        = frame_done;
            end
            default: ;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q;
        if (last_push) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        // A drop in the clear cycle still counts, on top of the zeroed total.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_stats) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clear_stats) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    tracer_trace_fifo #(
        .Width (TRACE_W + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (s_axi_aclk),
        .rst_ni      (s_axi_aresetn),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (m_axis.m_tready),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign m_axis.m_tvalid = fifo_valid;
    assign m_axis.m_tdata  = fifo_head[TRACE_W-1:0];
    assign m_axis.m_tlast  = fifo_head[TRACE_W];

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_tracer_trace_collector.sv
// Queue-level reference model of the collector checked every cycle, plus directed literal checks.
module tb_tracer_trace_collector;

    localparam int unsigned N = 4;
    localparam int unsigned D = 8;
    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_done = 1'b0;
    logic          clear_stats = 1'b0;
    logic          store_trace, busy, overflow;
    logic [W-1:0]  chain_trace;
    logic [15:0]   frame_cnt, drop_cnt;
    logic          ready_drv = 1'b0;

    tracer_trace_collector_if #(.TRACE_W(W)) axis ();
    assign axis.m_tready = ready_drv;

    tracer_trace_collector #(
        .NUM_ELEM   (N),
        .TRACE_W    (W),
        .FIFO_DEPTH (D)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .frame_done    (frame_done),
        .clear_stats   (clear_stats),
        .store_trace   (store_trace),
        .chain_trace   (chain_trace),
        .m_axis        (axis),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Element chain: tail drives chain_trace, each store_trace edge shifts toward the tail.
    logic [W-1:0]   elem [N];
    logic           load_req = 1'b0;
    logic [N*W-1:0] load_vals = '0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) elem[i] <= load_vals[i*W +: W];
        end else if (store_trace) begin
            for (int i = N - 1; i > 0; i--) elem[i] <= elem[i-1];
            elem[0] <= '0;
        end
    end
    assign chain_trace = elem[N-1];

    // Consumer ready: fixed or random, always changed 1 time unit after the edge.
    logic rand_ready = 1'b0;
    logic ready_fix  = 1'b1;
    always @(posedge clk) begin
        #1;
        ready_drv = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    // Reference model: expected stream contents, pending words of the current frame, stats.
    logic [W:0] exp_q [$];
    logic [W:0] pend  [$];
    int         rem = 0;
    logic [15:0] m_frames = '0;
    logic [15:0] m_drops  = '0;
    logic        m_ovf    = 1'b0;
    int          m_sz;
    bit          m_admit, m_drop, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            pend.delete();
            rem      = 0;
            m_frames = '0;
            m_drops  = '0;
            m_ovf    = 1'b0;
        end else begin
            m_sz    = exp_q.size();
            m_admit = frame_done && (rem == 0) && ((D - m_sz) >= N);
            m_drop  = frame_done && !m_admit;
            m_pop   = (m_sz != 0) && ready_drv;
            if (m_pop) void'(exp_q.pop_front());
            if (rem > 0) begin
                check("push_while_full", m_sz < D, 1);
                exp_q.push_back(pend.pop_front());
                rem--;
                if (rem == 0) m_frames = m_frames + 16'd1;
            end
            if (m_admit) begin
                rem = N;
                for (int i = N - 1; i >= 0; i--) pend.push_back({(i == 0), elem[i]});
            end
            if (m_drop) begin
                m_ovf = 1'b1;
                if (clear_stats) m_drops = 16'd1;
                else if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end else if (clear_stats) begin
                m_drops = '0;
                m_ovf   = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, stall stability, and capture of popped words.
    logic [W:0] seen [$];
    logic       pv = 1'b0, pr = 1'b0;
    logic [W:0] pd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            check("store_trace", store_trace, rem > 0);
            check("busy", busy, rem > 0);
            check("m_tvalid", axis.m_tvalid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("m_tdata", axis.m_tdata, exp_q[0][W-1:0]);
                check("m_tlast", axis.m_tlast, exp_q[0][W]);
            end
            if (pv && !pr && axis.m_tvalid) begin
                check("stall_stable", {axis.m_tlast, axis.m_tdata}, pd);
            end
            check("frame_cnt", frame_cnt, m_frames);
            check("drop_cnt", drop_cnt, m_drops);
            check("overflow", overflow, m_ovf);
            if (axis.m_tvalid && axis.m_tready) seen.push_back({axis.m_tlast, axis.m_tdata});
            pv = axis.m_tvalid;
            pr = axis.m_tready;
            pd = {axis.m_tlast, axis.m_tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_chain(input logic [N*W-1:0] v);
        load_vals = v;
        load_req  = 1'b1;
        tick();
        load_req  = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_shift_done();
        int k = 0;
        while (rem != 0 && k < 200) begin tick(); k++; end
        check("shift_done_in_budget", busy, 0);
    endtask

    task automatic wait_empty();
        int k = 0;
        while ((rem != 0 || exp_q.size() != 0) && k < 1000) begin tick(); k++; end
        check("drained_in_budget", axis.m_tvalid, 0);
    endtask

    task automatic wait_room();
        int k = 0;
        while ((rem != 0 || exp_q.size() > D - N) && k < 1000) begin tick(); k++; end
        check("room_in_budget", busy, 0);
    endtask

    // Words of one frame as seen on the stream: element N-1 first, tlast on element 0.
    task automatic check_frame(input string name, input int base, input logic [N*W-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (base + k < seen.size()) begin
                check(name, seen[base + k], {(k == N - 1), v[(N - 1 - k)*W +: W]});
            end else begin
                check({name, "_missing"}, base + k, seen.size());
            end
        end
    endtask

    initial begin
        int s0, stc, k;
        logic [N*W-1:0] fa, fb, fr;

        repeat (2) tick();
        check("rst_store_trace", store_trace, 0);
        check("rst_busy", busy, 0);
        check("rst_m_tvalid", axis.m_tvalid, 0);
        check("rst_m_tdata", axis.m_tdata, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Single frame, ready high.
        ready_fix = 1'b1;
        fa = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        load_chain(fa);
        s0 = seen.size();
        frame_done = 1'b1;
        @(negedge clk);
        check("t1_store_before", store_trace, 0);
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        stc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_store_first", store_trace, 1);
            stc += int'(store_trace);
        end
        check("t1_store_cycles", stc, 4);
        wait_empty();
        check_frame("t1_word", s0, fa);
        check("t1_frame_cnt", frame_cnt, 1);

        // Stalled consumer: two frames fill the FIFO, third is dropped.
        ready_fix = 1'b0;
        repeat (3) tick();
        fa = {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01};
        fb = {16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01};
        s0 = seen.size();
        load_chain(fa);
        pulse_frame();
        wait_shift_done();
        load_chain(fb);
        pulse_frame();
        wait_shift_done();
        check("t2_no_drop_yet", drop_cnt, 0);
        pulse_frame();
        @(negedge clk);
        check("t2_store_idle", store_trace, 0);
        check("t2_drop_cnt", drop_cnt, 1);
        check("t2_overflow", overflow, 1);
        tick();
        ready_fix = 1'b1;
        wait_empty();
        check("t2_words", seen.size() - s0, 8);
        check_frame("t2_frame_a", s0, fa);
        check_frame("t2_frame_b", s0 + N, fb);
        check("t2_frame_cnt", frame_cnt, 3);

        // frame_done during the second shift cycle.
        fa = {16'h0C04, 16'h0C03, 16'h0C02, 16'h0C01};
        load_chain(fa);
        s0 = seen.size();
        pulse_frame();
        tick();
        pulse_frame();
        wait_empty();
        check_frame("t3_word", s0, fa);
        check("t3_drop_cnt", drop_cnt, 2);
        check("t3_frame_cnt", frame_cnt, 4);

        // Count of 5 while draining leaves only 3 free: dropped.
        ready_fix = 1'b0;
        repeat (3) tick();
        load_chain({16'h0D04, 16'h0D03, 16'h0D02, 16'h0D01});
        pulse_frame();
        wait_shift_done();
        load_chain({16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01});
        pulse_frame();
        wait_shift_done();
        ready_fix = 1'b1;
        k = 0;
        while (exp_q.size() != 5 && k < 50) begin tick(); k++; end
        check("t4_reached_5", k < 50, 1);
        pulse_frame();
        check("t4_drop_cnt", drop_cnt, 3);
        check("t4_busy", busy, 0);
        wait_empty();
        check("t4_frame_cnt", frame_cnt, 6);

        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("clr_drop_cnt", drop_cnt, 0);
        check("clr_overflow", overflow, 0);

        // Random backpressure over 20 frames.
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            wait_room();
            for (int i = 0; i < N; i++) fr[i*W +: W] = W'($urandom);
            load_chain(fr);
            pulse_frame();
        end
        wait_empty();
        check("t5_frame_cnt", frame_cnt, 26);
        check("t5_drop_cnt", drop_cnt, 0);
        rand_ready = 1'b0;
        ready_fix  = 1'b1;
        repeat (2) tick();

        // Asynchronous reset during the first shift cycle.
        load_chain({16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01});
        pulse_frame();
        #2;
        check("t6_store_pre", store_trace, 1);
        rst_n = 1'b0;
        #1;
        check("t6_store_async", store_trace, 0);
        check("t6_busy_async", busy, 0);
        check("t6_tvalid_async", axis.m_tvalid, 0);
        check("t6_frame_cnt_async", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        fa = {16'h1004, 16'h1003, 16'h1002, 16'h1001};
        load_chain(fa);
        s0 = seen.size();
        pulse_frame();
        wait_empty();
        check_frame("t6_word", s0, fa);
        check("t6_frame_cnt", frame_cnt, 1);

        // Drop, then drop coincident with clear, then clear alone.
        load_chain({16'h1104, 16'h1103, 16'h1102, 16'h1101});
        pulse_frame();
        pulse_frame();
        check("t6_drop1", drop_cnt, 1);
        wait_empty();
        load_chain({16'h1204, 16'h1203, 16'h1202, 16'h1201});
        pulse_frame();
        frame_done  = 1'b1;
        clear_stats = 1'b1;
        tick();
        frame_done  = 1'b0;
        clear_stats = 1'b0;
        check("t6_drop_wins_cnt", drop_cnt, 1);
        check("t6_drop_wins_ovf", overflow, 1);
        wait_empty();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("t6_clear_cnt", drop_cnt, 0);
        check("t6_clear_ovf", overflow, 0);
        check("t6_final_frames", frame_cnt, 3);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1);
    end

endmodule
